// File: rtl/feature_map_streamer_pkg.sv
// Shared definitions for the feature-map streamer: FSM encoding, clog2 and the pixel channel macro.
// Channel 0 occupies the most significant D_WIDTH bits of a packed pixel.
`ifndef FMS_PIXEL_CH
`define FMS_PIXEL_CH(px, ch, w, n) px[((n)-1-(ch))*(w) +: (w)]
`endif

package feature_map_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/feature_map_streamer_raster_counter.sv
// raster_counter: row/col raster position with enable; col wraps after LAST and carries into row.
// Also used by the convolutional layer's output indexing.
module raster_counter #(
    parameter int WIDTH = 6,
    parameter int LAST  = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] row,
    output logic [WIDTH-1:0] col,
    output logic             last_col,
    output logic             last_pixel
);

    assign last_col   = (col == WIDTH'(LAST));
    assign last_pixel = last_col && (row == WIDTH'(LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (last_col) begin
                col <= '0;
                row <= last_pixel ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/feature_map_streamer.sv
// feature_map_streamer: reads one frame from a synchronous RAM and streams it in raster order.
// Define FEATURE_MAP_STREAMER_ZERO_PAD_EN to wrap the frame in a one-pixel zero border.
module feature_map_streamer
    import feature_map_streamer_pkg::*;
#(
    parameter int D_WIDTH    = 8,
    parameter int D_CHANNELS = 2,
    parameter int IMAGE_SIZE = 64,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clk_en,
    input  logic                          start,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_rd_en,
    input  logic [D_CHANNELS*D_WIDTH-1:0] mem_data,
    output logic [D_CHANNELS*D_WIDTH-1:0] pixel_data,
    output logic                          valid,
    output logic                          sof,
    output logic                          eol,
    output logic                          eof,
    output logic                          busy
);

    localparam int IDX_W = clog2(IMAGE_SIZE);
`ifdef FEATURE_MAP_STREAMER_ZERO_PAD_EN
    localparam int CNT_W = IDX_W + 1;
    localparam int LAST  = IMAGE_SIZE + 1;
`else
    localparam int CNT_W = IDX_W;
    localparam int LAST  = IMAGE_SIZE - 1;
`endif

    state_t                          state;
    logic [CNT_W-1:0]                row;
    logic [CNT_W-1:0]                col;
    logic                            last_col;
    logic                            last_pixel;
    logic                            accept;
    logic                            issue;
    logic                            border;
    logic [ADDR_WIDTH-1:0]           addr_next;
    logic [D_CHANNELS*D_WIDTH-1:0]   pix_next;
    logic                            rd_q;
    logic                            vld_p0, pad_p0, sof_p0, eol_p0, eof_p0;
    logic                            vld_p1, pad_p1, sof_p1, eol_p1, eof_p1;

    assign accept    = clk_en && (state == ST_IDLE) && start;
    assign issue     = accept || (clk_en && (state == ST_READ));
    // Gating the enable on a stall keeps the RAM output register frozen with the pipeline.
    assign mem_rd_en = rd_q && clk_en;

    raster_counter #(
        .WIDTH (CNT_W),
        .LAST  (LAST)
    ) u_raster (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (issue),
        .row        (row),
        .col        (col),
        .last_col   (last_col),
        .last_pixel (last_pixel)
    );

`ifdef FEATURE_MAP_STREAMER_ZERO_PAD_EN
    logic [IDX_W-1:0] row_i;
    logic [IDX_W-1:0] col_i;

    // Padded coordinates are offset by one; the border ring never touches the RAM.
    always_comb begin
        row_i     = IDX_W'(row - CNT_W'(1));
        col_i     = IDX_W'(col - CNT_W'(1));
        border    = (row == '0) || (row == CNT_W'(LAST)) || (col == '0) || last_col;
        addr_next = ADDR_WIDTH'({row_i, col_i});
    end
`else
    always_comb begin
        border    = 1'b0;
        addr_next = ADDR_WIDTH'({row, col});
    end
`endif

    always_comb begin
        pix_next = '0;
        if (!pad_p1) begin
            for (int ch = 0; ch < D_CHANNELS; ch++) begin
                `FMS_PIXEL_CH(pix_next, ch, D_WIDTH, D_CHANNELS) =
                    `FMS_PIXEL_CH(mem_data, ch, D_WIDTH, D_CHANNELS);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            mem_addr   <= '0;
            rd_q       <= 1'b0;
            vld_p0     <= 1'b0;
            pad_p0     <= 1'b0;
            sof_p0     <= 1'b0;
            eol_p0     <= 1'b0;
            eof_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            pad_p1     <= 1'b0;
            sof_p1     <= 1'b0;
            eol_p1     <= 1'b0;
            eof_p1     <= 1'b0;
            pixel_data <= '0;
            valid      <= 1'b0;
            sof        <= 1'b0;
            eol        <= 1'b0;
            eof        <= 1'b0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_READ;
                        busy  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (last_pixel) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (valid && eof) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Stage p0: address issued to the RAM, markers taken from the raster position
            rd_q   <= issue && !border;
            if (issue && !border) mem_addr <= addr_next;
            vld_p0 <= issue;
            pad_p0 <= issue && border;
            sof_p0 <= issue && (row == '0) && (col == '0);
            eol_p0 <= issue && last_col;
            eof_p0 <= issue && last_pixel;

            // Stage p1: RAM read data now present on mem_data
            vld_p1 <= vld_p0;
            pad_p1 <= pad_p0;
            sof_p1 <= sof_p0;
            eol_p1 <= eol_p0;
            eof_p1 <= eof_p0;

            // Output stage
            valid <= vld_p1;
            sof   <= sof_p1;
            eol   <= eol_p1;
            eof   <= eof_p1;
            if (vld_p1) pixel_data <= pix_next;
        end
    end

endmodule
